// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer and the bus processor control unit:
// op codes, instruction word fields and sequencer state encodings.
package prog_sequencer_pkg;

  localparam int DATA_W = 8;

  // Instruction word fields: [7] unused, [6:4] op, [3:2] X, [1:0] Y.
  localparam int OP_MSB   = 6;
  localparam int OP_LSB   = 4;
  localparam int HALT_BIT = 6;
  localparam int X_MSB    = 3;
  localparam int X_LSB    = 2;
  localparam int Y_MSB    = 1;
  localparam int Y_LSB    = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_FIN,
    ST_ERR
  } state_t;

  // Op code field of an instruction word.
  function automatic logic [2:0] word_op(input logic [DATA_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/prog_sequencer_mem.sv
// Program memory: synchronous write, two asynchronous read ports (instruction and the word after it).
module prog_sequencer_mem
  import prog_sequencer_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [2**AW];

  // Write port.
  // NOTE: the storage array has no reset; a reset loop over every word would turn the array into flops and the program is always reloaded anyway.
  always_ff @(posedge Clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction-issue master for the 8-bit bus processor: steps through a loaded program,
// drives DIN/Run and waits for Done, with HALT, truncated-mvi and timeout detection.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Ld_en,
  input  logic [AW-1:0]     Ld_addr,
  input  logic [DATA_W-1:0] Ld_data,
  input  logic [AW:0]       Prog_len,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic              Err,
  output logic [AW-1:0]     PC,
  output logic [7:0]        Instr_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [AW:0]       pc;
  logic [AW:0]       len;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] imm;
  logic [AW:0]       pc_plus1;
  logic [AW:0]       pc_adv;
  logic              is_mvi;
  logic              is_halt;
  logic              truncated;

  prog_sequencer_mem #(.AW(AW)) u_mem (
    .Clk       (Clk),
    .we        (Ld_en && !Busy),
    .wr_addr   (Ld_addr),
    .wr_data   (Ld_data),
    .rd_addr_a (pc[AW-1:0]),
    .rd_data_a (word),
    .rd_addr_b (pc_plus1[AW-1:0]),
    .rd_data_b (imm)
  );

  // PC arithmetic is one bit wider than the address so len==DEPTH ends cleanly without wrap.
  assign pc_plus1  = pc + 1'b1;
  assign is_mvi    = (word_op(word) == OP_MVI);
  assign is_halt   = word[HALT_BIT];
  assign pc_adv    = is_mvi ? pc + 2'd2 : pc_plus1;
  assign truncated = is_mvi && (pc_plus1 >= len);
  assign PC        = pc[AW-1:0];

  // Processor-facing drive: opcode word in ISSUE, mvi immediate during EXEC, idle otherwise.
  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    DIN = '0;
    Run = 1'b0;
    case (state)
      ST_ISSUE: begin
        DIN = word;
        Run = !is_halt && !truncated;
      end
      ST_EXEC: DIN = is_mvi ? imm : '0;
      default: ;
    endcase
  end

  // Sequencer FSM with counters; status outputs are registered alongside the next state.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      pc        <= '0;
      len       <= '0;
      tcnt      <= '0;
      Instr_cnt <= '0;
      Busy      <= 1'b0;
      Finished  <= 1'b0;
      Err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN, ST_ERR: begin
          if (Start) begin
            len       <= Prog_len;
            pc        <= '0;
            Instr_cnt <= '0;
            Err       <= 1'b0;
            if (Prog_len == '0) begin
              state    <= ST_FIN;
              Finished <= 1'b1;
              Busy     <= 1'b0;
            end else begin
              state    <= ST_ISSUE;
              Finished <= 1'b0;
              Busy     <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (is_halt) begin
            state    <= ST_FIN;
            Busy     <= 1'b0;
            Finished <= 1'b1;
          end else if (truncated) begin
            state <= ST_ERR;
            Busy  <= 1'b0;
            Err   <= 1'b1;
          end else begin
            state <= ST_EXEC;
            tcnt  <= '0;
          end
        end
        ST_EXEC: begin
          if (Done) begin
            pc <= pc_adv;
            if (Instr_cnt != 8'hFF) Instr_cnt <= Instr_cnt + 8'd1;
            if (pc_adv >= len) begin
              state    <= ST_FIN;
              Busy     <= 1'b0;
              Finished <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= ST_ERR;
            Busy  <= 1'b0;
            Err   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer with a behavioural model of the 8-bit bus processor.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic          Ld_en = 1'b0;
  logic [AW-1:0] Ld_addr = '0;
  logic [7:0]    Ld_data = '0;
  logic [AW:0]   Prog_len = '0;
  logic          Done;
  logic [7:0]    DIN;
  logic          Run, Busy, Finished, Err;
  logic [AW-1:0] PC;
  logic [7:0]    Instr_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  issue_q[$];
  int          run_total = 0;
  int          wide_total = 0;
  logic        run_prev = 1'b0;
  logic        block_done = 1'b0;

  prog_sequencer dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .Ld_en(Ld_en), .Ld_addr(Ld_addr),
    .Ld_data(Ld_data), .Prog_len(Prog_len), .Done(Done), .DIN(DIN), .Run(Run),
    .Busy(Busy), .Finished(Finished), .Err(Err), .PC(PC), .Instr_cnt(Instr_cnt)
  );

  always #5 Clk = ~Clk;

  // ---------------- processor model ----------------
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  step_t      step;
  logic [7:0] ir, a_reg, g_reg;
  logic [7:0] rf [4];
  logic       p_done;

  assign p_done = ((step == T1) && (ir[6:5] == 2'b00)) || (step == T3);
  assign Done   = p_done && !block_done;

  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      step <= T0;
      ir   <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (step)
        T0: if (Run) begin ir <= DIN; step <= T1; end
        T1: begin
          case (ir[6:4])
            3'b000: begin rf[ir[3:2]] <= rf[ir[1:0]]; step <= T0; end
            3'b001: begin rf[ir[3:2]] <= DIN; step <= T0; end
            default: begin a_reg <= rf[ir[3:2]]; step <= T2; end
          endcase
        end
        T2: begin
          g_reg <= (ir[6:4] == 3'b010) ? a_reg + rf[ir[1:0]] : a_reg - rf[ir[1:0]];
          step  <= T3;
        end
        default: begin rf[ir[3:2]] <= g_reg; step <= T0; end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every issued word must match the next expected opcode word.
  always @(negedge Clk) begin
    if (Run === 1'b1) begin
      run_total++;
      if (run_prev) wide_total++;
      check("run_expected", 32'(issue_q.size() > 0), 32'd1);
      if (issue_q.size() > 0) check("issue_din", 32'(DIN), 32'(issue_q.pop_front()));
    end
    run_prev = Run;
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Resetn = 1'b1;
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [7:0] data);
    @(posedge Clk);
    #1 Ld_en = 1'b1; Ld_addr = addr; Ld_data = data;
    @(posedge Clk);
    #1 Ld_en = 1'b0;
  endtask

  task automatic start_run(input logic [AW:0] len);
    @(posedge Clk);
    #1 Start = 1'b1; Prog_len = len;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Counts cycles from the Start cycle through the first FIN/ERR cycle inclusive.
  task automatic wait_end(output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      cycles++;
      if (Finished || Err) seen = 1'b1;
    end
    check("run_ended", 32'(seen), 32'd1);
  endtask

  int cyc, run0, wide0;

  initial begin
    // Reset state
    #2;
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_fin", 32'(Finished), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_cnt", 32'(Instr_cnt), 32'd0);
    do_reset();

    // HALT at PC=2: mvi R0,5 ; HALT ; (mvi R1,9 never runs)
    load_word(0, 8'h10); load_word(1, 8'h05); load_word(2, 8'h40);
    load_word(3, 8'h14); load_word(4, 8'h09);
    issue_q.push_back(8'h10);
    run0 = run_total;
    start_run(5);
    wait_end(cyc);
    check("halt_fin", 32'(Finished), 32'd1);
    check("halt_cnt", 32'(Instr_cnt), 32'd1);
    check("halt_pc", 32'(PC), 32'd2);
    check("halt_r0", 32'(rf[0]), 32'd5);
    check("halt_r1", 32'(rf[1]), 32'd0);
    check("halt_cycles", 32'(cyc), 32'd5);
    check("halt_runs", 32'(run_total - run0), 32'd1);

    // mvi R0,5 ; mvi R1,3 ; add R0,R1 ; mv R2,R0
    do_reset();
    load_word(0, 8'h10); load_word(1, 8'h05); load_word(2, 8'h14);
    load_word(3, 8'h03); load_word(4, 8'h21); load_word(5, 8'h08);
    issue_q.push_back(8'h10); issue_q.push_back(8'h14);
    issue_q.push_back(8'h21); issue_q.push_back(8'h08);
    start_run(6);
    wait_end(cyc);
    check("p1_r0", 32'(rf[0]), 32'd8);
    check("p1_r1", 32'(rf[1]), 32'd3);
    check("p1_r2", 32'(rf[2]), 32'd8);
    check("p1_cnt", 32'(Instr_cnt), 32'd4);
    check("p1_fin", 32'(Finished), 32'd1);
    check("p1_busy", 32'(Busy), 32'd0);
    check("p1_pc", 32'(PC), 32'd6);
    // Start cycle + 2+2+4+2 busy cycles + FIN cycle
    check("p1_cycles", 32'(cyc), 32'd12);
    check("p1_q_empty", 32'(issue_q.size()), 32'd0);

    // mvi R0,7 ; mvi R1,2 ; sub R0,R1 with a Start and a load attempted mid-run
    do_reset();
    load_word(0, 8'h10); load_word(1, 8'h07); load_word(2, 8'h14);
    load_word(3, 8'h02); load_word(4, 8'h31);
    issue_q.push_back(8'h10); issue_q.push_back(8'h14); issue_q.push_back(8'h31);
    run0 = run_total; wide0 = wide_total;
    start_run(5);
    @(posedge Clk);
    #1 Start = 1'b1; Prog_len = '0; Ld_en = 1'b1; Ld_addr = 3; Ld_data = 8'h07;
    @(posedge Clk);
    #1 Start = 1'b0; Ld_en = 1'b0;
    wait_end(cyc);
    check("p2_r0", 32'(rf[0]), 32'd5);
    check("p2_r1", 32'(rf[1]), 32'd2);
    check("p2_cnt", 32'(Instr_cnt), 32'd3);
    check("p2_fin", 32'(Finished), 32'd1);
    check("p2_runs", 32'(run_total - run0), 32'd3);
    check("p2_wide_runs", 32'(wide_total - wide0), 32'd0);
    check("p2_q_empty", 32'(issue_q.size()), 32'd0);

    // Truncated mvi: single word 10, len=1
    do_reset();
    load_word(0, 8'h10);
    run0 = run_total;
    start_run(1);
    wait_end(cyc);
    check("tr_err", 32'(Err), 32'd1);
    check("tr_fin", 32'(Finished), 32'd0);
    check("tr_busy", 32'(Busy), 32'd0);
    check("tr_runs", 32'(run_total - run0), 32'd0);
    check("tr_cycles", 32'(cyc), 32'd3);
    start_run(0);
    check("tr_restart_err", 32'(Err), 32'd0);
    check("tr_restart_fin", 32'(Finished), 32'd1);

    // Timeout: Done held low after issuing add
    do_reset();
    load_word(0, 8'h21);
    issue_q.push_back(8'h21);
    block_done = 1'b1;
    start_run(1);
    wait_end(cyc);
    block_done = 1'b0;
    check("to_err", 32'(Err), 32'd1);
    check("to_busy", 32'(Busy), 32'd0);
    check("to_cnt", 32'(Instr_cnt), 32'd0);
    // Start cycle + ISSUE + 8 EXEC cycles + ERR cycle
    check("to_cycles", 32'(cyc), 32'd11);

    // Reset in EXEC of add, then restart, then len=0
    do_reset();
    load_word(0, 8'h21);
    issue_q.push_back(8'h21);
    start_run(1);
    @(negedge Clk);
    check("rs_issue_busy", 32'(Busy), 32'd1);
    @(posedge Clk);
    #2 Resetn = 1'b0;
    #1;
    check("rs_din", 32'(DIN), 32'd0);
    check("rs_run", 32'(Run), 32'd0);
    check("rs_busy", 32'(Busy), 32'd0);
    check("rs_fin", 32'(Finished), 32'd0);
    check("rs_err", 32'(Err), 32'd0);
    check("rs_pc", 32'(PC), 32'd0);
    check("rs_cnt", 32'(Instr_cnt), 32'd0);
    @(posedge Clk);
    #1 Resetn = 1'b1;
    issue_q.push_back(8'h21);
    start_run(1);
    check("rs_restart_pc", 32'(PC), 32'd0);
    check("rs_restart_run", 32'(Run), 32'd1);
    wait_end(cyc);
    check("rs_restart_fin", 32'(Finished), 32'd1);
    check("rs_restart_cnt", 32'(Instr_cnt), 32'd1);
    start_run(0);
    check("len0_fin", 32'(Finished), 32'd1);
    check("len0_busy", 32'(Busy), 32'd0);
    check("len0_cnt", 32'(Instr_cnt), 32'd0);
    check("final_q_empty", 32'(issue_q.size()), 32'd0);

    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
